// File: rtl/sd_reader_pkg.sv
// Shared definitions for the SD sector reader and the arbiter that fronts it:
// card status codes, card type, sector size and arbiter FSM states.
package sd_reader_pkg;

  localparam logic [3:0] CARD_IDLE = 4'd8;
  localparam logic [3:0] CARD_READ = 4'd9;

  localparam int SECTOR_BYTES = 512;

  // Wide enough to see one byte past a full sector before saturating.
  localparam int              CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    CARD_NONE,
    CARD_SD1,
    CARD_SD2,
    CARD_SDHC
  } card_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after
// the pointer, wrapping cyclically through NREQ requesters.
module sd_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);

  int          cand;
  logic [IW-1:0] cand_w;

  // Scan from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    cand_w  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand   = (int'(ptr_i) + i) % NREQ;
      cand_w = IW'(cand);
      if (req_i[cand_w]) begin
        valid_o = 1'b1;
        idx_o   = cand_w;
      end
    end
  end

endmodule

// File: rtl/sd_sector_read_arbiter.sv
// Shares one SPI sector reader between NREQ requesters: round-robin grants of whole
// sectors, readout steering to the winner, and a byte-count integrity flag at done.
module sd_sector_read_arbiter #(
  parameter int         NREQ      = 4,
  parameter logic [3:0] CARD_IDLE = sd_reader_pkg::CARD_IDLE,
  parameter logic [3:0] CARD_READ = sd_reader_pkg::CARD_READ
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ*32-1:0] req_sector_i,
  output logic [NREQ-1:0]  ack_o,
  output logic [NREQ-1:0]  done_o,
  output logic [NREQ-1:0]  err_o,
  output logic [NREQ-1:0]  rvalid_o,
  output logic [8:0]       raddr_o,
  output logic [7:0]       rdata_o,
  output logic             busy_o,
  output logic             rd_start_o,
  output logic [31:0]      rd_sector_no_o,
  input  logic             rd_done_i,
  input  logic             rd_rvalid_i,
  input  logic [8:0]       rd_raddr_i,
  input  logic [7:0]       rd_rdata_i,
  input  logic [3:0]       rd_card_stat_i
);

  import sd_reader_pkg::*;

  localparam int IW = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc, cnt_fin;
  logic [31:0]       sector_q, sector_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [8:0]        raddr_q, raddr_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_oh, gnt_oh;
  logic [31:0]       sec_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_sec
    assign sec_arr[i] = req_sector_i[32*i +: 32];
  end

  sd_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign pick_oh = NREQ'(1) << pick_idx;
  assign gnt_oh  = NREQ'(1) << gnt_q;

  // A byte arriving together with rd_done still counts toward the integrity check.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign cnt_fin = rd_rvalid_i ? cnt_inc : cnt_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    sector_d = sector_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    done_d   = '0;
    err_d    = '0;
    rvalid_d = '0;
    raddr_d  = '0;
    rdata_d  = '0;
    busy_d   = busy_q;
    start_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (rd_card_stat_i == CARD_IDLE && pick_valid) begin
          gnt_d    = pick_idx;
          sector_d = sec_arr[pick_idx];
          ack_d    = pick_oh;
          busy_d   = 1'b1;
          state_d  = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        if (rd_card_stat_i == CARD_READ) begin
          state_d = ARB_WAIT;
        end else begin
          start_d = 1'b1;
        end
      end

      ARB_WAIT: begin
        if (rd_rvalid_i) begin
          rvalid_d = gnt_oh;
          raddr_d  = rd_raddr_i;
          rdata_d  = rd_rdata_i;
          cnt_d    = cnt_inc;
        end
        if (rd_done_i) begin
          done_d  = gnt_oh;
          err_d   = (cnt_fin != CNT_W'(SECTOR_BYTES)) ? gnt_oh : '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = IW'((int'(gnt_q) + 1) % NREQ);
          state_d = ARB_IDLE;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      sector_q <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      sector_q <= sector_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign ack_o          = ack_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign rvalid_o       = rvalid_q;
  assign raddr_o        = raddr_q;
  assign rdata_o        = rdata_q;
  assign busy_o         = busy_q;
  assign rd_start_o     = start_q;
  assign rd_sector_no_o = sector_q;

endmodule

// File: tb/tb_sd_sector_read_arbiter.sv
// Self-checking bench: a simple reader BFM plus a round-robin grant model that predicts
// winner, sector, steered bytes and integrity flag for directed and random requests.
module tb_sd_sector_read_arbiter;

  localparam int         NREQ  = 4;
  localparam logic [3:0] ST_IDLE = 4'd8;
  localparam logic [3:0] ST_READ = 4'd9;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] req_sector;
  logic [NREQ-1:0]    ack, done, err, rvalid;
  logic [8:0]         raddr;
  logic [7:0]         rdata;
  logic               busy, rd_start;
  logic [31:0]        rd_sector_no;
  logic               rd_done, rd_rvalid;
  logic [8:0]         rd_raddr;
  logic [7:0]         rd_rdata;
  logic [3:0]         card_stat;

  logic [31:0] sec [NREQ];
  int checks   = 0;
  int failures = 0;
  int modelPtr = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_sector = '0;
    for (int i = 0; i < NREQ; i++) req_sector[32*i +: 32] = sec[i];
  end

  sd_sector_read_arbiter #(.NREQ(NREQ)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_sector_i   (req_sector),
    .ack_o          (ack),
    .done_o         (done),
    .err_o          (err),
    .rvalid_o       (rvalid),
    .raddr_o        (raddr),
    .rdata_o        (rdata),
    .busy_o         (busy),
    .rd_start_o     (rd_start),
    .rd_sector_no_o (rd_sector_no),
    .rd_done_i      (rd_done),
    .rd_rvalid_i    (rd_rvalid),
    .rd_raddr_i     (rd_raddr),
    .rd_rdata_i     (rd_rdata),
    .rd_card_stat_i (card_stat)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // First requester at or after the model pointer, counting cyclically.
  function automatic int modelPick(input logic [NREQ-1:0] r);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (modelPtr + k) % NREQ;
      if (((r >> idx) & NREQ'(1)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic checkIdle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput(tag, 64'({ack, rd_start, busy}), 64'(0));
    end
  endtask

  task automatic applyStimulus(input int nbytes, input bit dropReq, input bit coincide,
                               input int resetAt, output int g);
    int              expG, lat, sent, hold;
    bit              gotAck;
    logic [NREQ-1:0] oh, expRv, expDone, expErr;
    logic [8:0]      expAddr;
    logic [7:0]      expData;
    g      = -1;
    expG   = modelPick(req);
    gotAck = 1'b0;
    lat    = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        gotAck = 1'b1;
        lat    = k;
        break;
      end
    end
    checkOutput("ack_seen", 64'(gotAck), 64'(1));
    if (!gotAck || expG < 0) return;
    oh = NREQ'(1) << expG;
    checkOutput("ack_latency", 64'(lat), 64'(0));
    checkOutput("ack_onehot", 64'(ack), 64'(oh));
    checkOutput("sector_no", 64'(rd_sector_no), 64'(sec[expG]));
    checkOutput("busy_at_ack", 64'(busy), 64'(1));
    if (dropReq) req[expG] = 1'b0;

    hold = $urandom_range(0, 3);
    for (int j = 0; j <= hold; j++) begin
      @(negedge clk);
      checkOutput("rd_start_hold", 64'({rd_start, ack}), 64'({1'b1, NREQ'(0)}));
    end
    card_stat = ST_READ;
    @(negedge clk);
    checkOutput("rd_start_drop", 64'(rd_start), 64'(0));

    sent = 0;
    for (int cyc = 0; sent < nbytes && cyc < 2000; cyc++) begin
      if (resetAt >= 0 && sent == resetAt) begin
        rd_rvalid = 1'b0;
        rd_done   = 1'b0;
        card_stat = ST_IDLE;
        rst_n     = 1'b0;
        @(negedge clk);
        checkOutput("reset_ctrl", 64'({ack, done, err, rvalid, raddr, rdata, busy, rd_start}), 64'(0));
        checkOutput("reset_sector", 64'(rd_sector_no), 64'(0));
        rst_n    = 1'b1;
        modelPtr = 0;
        g        = expG;
        return;
      end
      if ($urandom_range(0, 15) == 0) begin
        rd_rvalid = 1'b0;
        rd_raddr  = 9'($urandom);
        rd_rdata  = 8'($urandom);
        expRv = '0; expAddr = '0; expData = '0;
      end else begin
        rd_rvalid = 1'b1;
        rd_raddr  = 9'(sent);
        rd_rdata  = 8'($urandom);
        expRv = oh; expAddr = rd_raddr; expData = rd_rdata;
        sent++;
      end
      rd_done = coincide && rd_rvalid && (sent == nbytes);
      expDone = rd_done ? oh : '0;
      expErr  = (rd_done && nbytes != 512) ? oh : '0;
      @(negedge clk);
      checkOutput("rvalid", 64'(rvalid), 64'(expRv));
      checkOutput("raddr", 64'(raddr), 64'(expAddr));
      checkOutput("rdata", 64'(rdata), 64'(expData));
      checkOutput("done_err", 64'({done, err}), 64'({expDone, expErr}));
      checkOutput("busy_start", 64'({busy, rd_start}), 64'({~rd_done, 1'b0}));
    end

    if (!coincide) begin
      rd_rvalid = 1'b0;
      rd_done   = 1'b1;
      card_stat = ST_IDLE;
      @(negedge clk);
      checkOutput("done_sep", 64'(done), 64'(oh));
      checkOutput("err_sep", 64'(err), 64'((nbytes != 512) ? oh : NREQ'(0)));
      checkOutput("busy_end", 64'({busy, rvalid}), 64'(0));
    end
    rd_done   = 1'b0;
    rd_rvalid = 1'b0;
    rd_raddr  = '0;
    rd_rdata  = '0;
    card_stat = ST_IDLE;
    modelPtr  = (expG + 1) % NREQ;
    g         = expG;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl", 64'({ack, done, err, rvalid, raddr, rdata, busy, rd_start}), 64'(0));
    checkOutput("rst_sector", 64'(rd_sector_no), 64'(0));
    rst_n    = 1'b1;
    modelPtr = 0;
  endtask

  initial begin
    int g;
    int fairExp [5];
    int sizes [5];
    fairExp = '{0, 1, 2, 3, 0};
    sizes   = '{512, 512, 511, 513, 500};
    req = '0; card_stat = 4'd0;
    rd_done = 1'b0; rd_rvalid = 1'b0; rd_raddr = '0; rd_rdata = '0;
    for (int i = 0; i < NREQ; i++) sec[i] = '0;
    doReset();

    // Basic single read from requester 0.
    card_stat = ST_IDLE;
    sec[0] = 32'h10;
    req = 4'b0001;
    applyStimulus(512, 1'b1, 1'b0, -1, g);
    checkOutput("basic_grant", 64'(g), 64'(0));

    // Fairness with all requesters held high from a fresh pointer.
    doReset();
    card_stat = ST_IDLE;
    for (int i = 0; i < NREQ; i++) sec[i] = $urandom;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      applyStimulus(512, 1'b0, t[0], -1, g);
      checkOutput("fair_order", 64'(g), 64'(fairExp[t]));
    end
    req = '0;

    // Card still initialising: no grant until it reports idle.
    card_stat = 4'd0;
    req = 4'b0010;
    checkIdle(6, "notready_idle");
    card_stat = ST_IDLE;
    applyStimulus(512, 1'b1, 1'b1, -1, g);
    checkOutput("notready_grant", 64'(g), 64'(1));

    // Short sector flags an error; the next one is clean.
    req = 4'b0001;
    applyStimulus(511, 1'b1, 1'b0, -1, g);
    req = 4'b0100;
    applyStimulus(512, 1'b1, 1'b1, -1, g);
    checkOutput("after_err_grant", 64'(g), 64'(2));

    // Request withdrawn before the card was ready.
    card_stat = 4'd0;
    req = 4'b0100;
    checkIdle(3, "withdraw_wait");
    req = '0;
    card_stat = ST_IDLE;
    checkIdle(5, "withdraw_idle");

    // Reset in the middle of the data phase, then a fresh read.
    sec[3] = $urandom;
    req = 4'b1000;
    applyStimulus(512, 1'b1, 1'b0, 200, g);
    sec[0] = $urandom;
    req = 4'b0001;
    applyStimulus(512, 1'b1, 1'b0, -1, g);
    checkOutput("post_reset_grant", 64'(g), 64'(0));

    // Randomised request mixes and byte counts.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NREQ; i++) sec[i] = $urandom;
      req = NREQ'($urandom_range(1, 15));
      applyStimulus(sizes[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
